// File: rtl/exp3_pkg.sv
// Shared definitions for the Experiencia 3 control unit: state codes (also shown
// on the 7-segment debug display), default timeout and the Moore output decode.
package exp3_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTOU   = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERROU     = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } controle_t;

  function automatic controle_t decodifica_saidas(input estado_t estado);
    controle_t c;
    c = '0;
    case (estado)
      PREPARACAO: begin
        c.zera_c = 1'b1;
        c.zera_r = 1'b1;
      end
      REGISTRA:    c.registra_r = 1'b1;
      PROXIMO:     c.conta_c = 1'b1;
      FIM_ACERTOU: begin
        c.pronto  = 1'b1;
        c.acertou = 1'b1;
      end
      FIM_ERROU: begin
        c.pronto = 1'b1;
        c.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        c.pronto  = 1'b1;
        c.timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exp3_unidade_controle_edge_detector.sv
// Rising-edge detector: one-cycle pulso on each low-to-high transition of sinal.
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic sinal,
  output logic pulso
);

  logic sinal_d_r;

  // previous-cycle copy of the input level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinal_d_r <= 1'b0;
    end else begin
      sinal_d_r <= sinal;
    end
  end

  assign pulso = sinal & ~sinal_d_r;

endmodule

// File: rtl/exp3_unidade_controle.sv
// Moore control unit sequencing the exp3 datapath: one round of 16 moves ending
// in win, mismatch or timeout. Outputs are registered from the next-state decode.
module exp3_unidade_controle
  import exp3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t       estado_r;
  estado_t       estado_next_s;
  logic [TW-1:0] timer_r;
  logic          jp_s;
  logic          expirou_s;
  controle_t     saidas_r;
  controle_t     saidas_next_s;

  edge_detector u_jogada_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sinal   (jogada),
    .pulso   (jp_s)
  );

  assign expirou_s = (timer_r == TW'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r <= INICIAL;
    end else begin
      estado_r <= estado_next_s;
    end
  end

  // wait timer: counts only while waiting for a move, so each wait starts at 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= '0;
    end else if (estado_r == ESPERA_JOGADA) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= '0;
    end
  end

  // next-state logic; a move edge beats a simultaneous timer expiry
  always_comb begin
    estado_next_s = estado_r;
    case (estado_r)
      INICIAL: begin
        if (iniciar) estado_next_s = PREPARACAO;
        else         estado_next_s = INICIAL;
      end
      PREPARACAO: estado_next_s = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jp_s)           estado_next_s = REGISTRA;
        else if (expirou_s) estado_next_s = FIM_TIMEOUT;
        else                estado_next_s = ESPERA_JOGADA;
      end
      REGISTRA: estado_next_s = COMPARACAO;
      COMPARACAO: begin
        if (!chavesIgualMemoria) estado_next_s = FIM_ERROU;
        else if (fimC)           estado_next_s = FIM_ACERTOU;
        else                     estado_next_s = PROXIMO;
      end
      PROXIMO: estado_next_s = ESPERA_JOGADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) estado_next_s = PREPARACAO;
        else         estado_next_s = estado_r;
      end
      default: estado_next_s = INICIAL;
    endcase
  end

  // decoding the next state keeps registered outputs aligned with estado_r
  always_comb begin
    saidas_next_s = decodifica_saidas(estado_next_s);
  end

  // output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      saidas_r <= '0;
    end else begin
      saidas_r <= saidas_next_s;
    end
  end

  assign zeraC     = saidas_r.zera_c;
  assign contaC    = saidas_r.conta_c;
  assign zeraR     = saidas_r.zera_r;
  assign registraR = saidas_r.registra_r;
  assign pronto    = saidas_r.pronto;
  assign acertou   = saidas_r.acertou;
  assign errou     = saidas_r.errou;
  assign timeout   = saidas_r.timeout;
  assign db_estado = estado_r;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Randomized scoreboard bench: the stimulus predicts each output event (cycle,
// state code, outputs) from the round rules; a negedge monitor pops and compares.
module tb_exp3_unidade_controle;

  localparam int T = 20;

  localparam logic [7:0] S_PREP = 8'b1010_0000;
  localparam logic [7:0] S_REG  = 8'b0001_0000;
  localparam logic [7:0] S_PROX = 8'b0100_0000;
  localparam logic [7:0] S_WIN  = 8'b0000_1100;
  localparam logic [7:0] S_ERR  = 8'b0000_1010;
  localparam logic [7:0] S_TO   = 8'b0000_1001;

  logic       clock, reset_n, iniciar, jogada, chavesIgualMemoria, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  typedef struct {
    int         cyc;
    logic [3:0] estado;
    logic [7:0] saidas;
    string      nome;
  } esperado_t;

  esperado_t fila[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        addr = 0;
  int        bad_idx = 16;
  int        rel_cyc = -10;
  logic      mon_on = 1'b0;
  logic      pronto_q = 1'b0;

  exp3_unidade_controle #(.TIMEOUT_CYCLES(T)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .iniciar            (iniciar),
    .jogada             (jogada),
    .chavesIgualMemoria (chavesIgualMemoria),
    .fimC               (fimC),
    .zeraC              (zeraC),
    .contaC             (contaC),
    .zeraR              (zeraR),
    .registraR          (registraR),
    .pronto             (pronto),
    .acertou            (acertou),
    .errou              (errou),
    .timeout            (timeout),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // datapath stand-in: address counter and a ROM that mismatches at bad_idx
  always @(posedge clock) begin
    if (zeraC)       addr <= 0;
    else if (contaC) addr <= addr + 1;
  end
  assign fimC               = (addr == 15);
  assign chavesIgualMemoria = (addr != bad_idx);

  // monitor
  always @(negedge clock) begin
    logic [7:0] s;
    esperado_t  e;
    s = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
    if (reset_n && mon_on) begin
      checks++;
      if (int'(zeraC) + int'(contaC) + int'(registraR) > 1) begin
        errors++;
        $display("FAIL exclusive_ctrl: got zeraC/contaC/registraR=%b%b%b at cyc %0d, required at most one", zeraC, contaC, registraR, cyc);
      end
      if (zeraC | contaC | registraR | (pronto & ~pronto_q)) begin
        checks++;
        if (fila.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got estado=%h saidas=%b at cyc %0d, required no event", db_estado, s, cyc);
        end else begin
          e = fila.pop_front();
          if (cyc != e.cyc || db_estado != e.estado || s != e.saidas) begin
            errors++;
            $display("FAIL %s: got cyc=%0d estado=%h saidas=%b, required cyc=%0d estado=%h saidas=%b",
                     e.nome, cyc, db_estado, s, e.cyc, e.estado, e.saidas);
          end
        end
      end
    end
    pronto_q = pronto;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got no end at time %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic push_ev(input int c, input logic [3:0] est, input logic [7:0] s, input string n);
    esperado_t e;
    e.cyc = c; e.estado = est; e.saidas = s; e.nome = n;
    fila.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    iniciar = 1'b0;
    if (cyc == rel_cyc) jogada = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_idle(input string n);
    logic [11:0] v;
    v = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
    checks++;
    if (v != 12'h000) begin
      errors++;
      $display("FAIL %s: got outputs/estado=%h, required 000", n, v);
    end
  endtask

  // one round from inicial or a fim state; bad=16 means every word matches,
  // to_move is the move left unplayed, held_move keeps jogada high hold_len cycles
  task automatic run_round(input int bad, input int to_move, input int held_move,
                           input int hold_len, input int force_k);
    int c0, e, k, kmin, fim, span;
    bad_idx = bad;
    iniciar = 1'b1;
    c0 = cyc;
    push_ev(c0 + 1, 4'h1, S_PREP, "preparacao");
    tick();
    e = c0 + 2;
    fim = e;
    for (int m = 0; m < 16; m++) begin
      kmin = (rel_cyc + 1 > e) ? rel_cyc + 1 - e : 0;
      if (m == to_move || kmin > T - 1) begin
        fim = e + T;
        push_ev(fim, 4'hD, S_TO, "fim_timeout");
        break;
      end
      if (m == 0 && force_k >= kmin) begin
        k = force_k;
      end else if ($urandom_range(0, 7) == 0) begin
        k = T - 1;
      end else begin
        span = (T - 1 - kmin < 3) ? T - 1 - kmin : 3;
        k = kmin + $urandom_range(0, span);
      end
      wait_until(e + k);
      jogada = 1'b1;
      rel_cyc = (m == held_move) ? e + k + hold_len : e + k + 1;
      if ($urandom_range(0, 3) == 0) iniciar = 1'b1;
      push_ev(e + k + 1, 4'h4, S_REG, "registra");
      if (m == bad) begin
        fim = e + k + 3;
        push_ev(fim, 4'hE, S_ERR, "fim_errou");
        break;
      end
      if (m == 15) begin
        fim = e + k + 3;
        push_ev(fim, 4'hA, S_WIN, "fim_acertou");
        break;
      end
      push_ev(e + k + 3, 4'h6, S_PROX, "proximo");
      e = e + k + 4;
    end
    wait_until(((fim > rel_cyc) ? fim : rel_cyc) + 1);
    repeat ($urandom_range(0, 2)) begin
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
      tick();
    end
  endtask

  task automatic reset_mid_round();
    int c0, e;
    bad_idx = 16;
    iniciar = 1'b1;
    c0 = cyc;
    push_ev(c0 + 1, 4'h1, S_PREP, "preparacao");
    tick();
    e = c0 + 2;
    wait_until(e + 3);
    jogada = 1'b1;
    rel_cyc = e + 4;
    push_ev(e + 4, 4'h4, S_REG, "registra");
    push_ev(e + 6, 4'h6, S_PROX, "proximo");
    wait_until(e + 6);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle("midreset_assert");
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("midreset_held");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("midreset_release");
    tick();
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b1;
    iniciar = 1'b0;
    jogada = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_idle("reset_assert");
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset_held");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("reset_release");
    mon_on = 1'b1;
    tick();

    run_round(16, 99, -1, 0, -1);
    run_round(2, 99, -1, 0, -1);
    run_round(16, 0, -1, 0, -1);
    run_round(1, 99, -1, 0, T - 1);
    run_round(16, 99, 0, 50, -1);
    run_round(16, 99, 1, 12, -1);
    reset_mid_round();
    run_round(16, 99, -1, 0, -1);
    for (int i = 0; i < 25; i++) begin
      run_round(($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 99,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                int'($urandom_range(2, 30)), -1);
    end

    repeat (3) tick();
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unseen, required 0 (next %s at cyc %0d)",
               fila.size(), fila[0].nome, fila[0].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp3_unidade_controle.md
Name: exp3_unidade_controle

Overview:
Moore control unit for the Experiência 3 circuit. It sequences the exp3 datapath: clears the counter and register, waits for each player move, registers the switches, and checks the compare result. It advances the address, and ends the round with a win, a loss or a timeout. It consumes the datapath status signals (chavesIgualMemoria, fimC) and drives its control inputs (zeraC, contaC, zeraR, registraR). Top level: exp3_circuito, unit and datapath sharing one clock.

Parameters:
TIMEOUT_CYCLES, 5000, clock cycles allowed in espera_jogada before timeout (min 2)
TW, $clog2(TIMEOUT_CYCLES), width of internal timeout counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
iniciar  input  1  level; starts or restarts a round
jogada  input  1  level from move button; only its rising edge is used
chavesIgualMemoria  input  1  datapath compare result (registered switches == ROM word)
fimC  input  1  datapath counter rco (address == 15)
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear switch register
registraR  output  1  load switch register
pronto  output  1  round finished
acertou  output  1  round ended with all 16 words matched
errou  output  1  round ended on mismatch
timeout  output  1  round ended by TIMEOUT_CYCLES expiry
db_estado  output  4  current state code (debug, 7-seg)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). Asserting reset_n=0 at any time, including mid-round, forces state inicial, timer=0, jogada_d=0. All outputs are 0 and db_estado=0 while reset is held and in the cycle after release.
- Outputs are Moore and decoded from the state register only. Every output not listed for a state is 0.
- Edge detect: jogada_d is jogada registered each cycle. jp = jogada & ~jogada_d.
  - A level held high across many cycles yields one jp.
  - jp outside espera_jogada is discarded and never queued.
- States, codes and transitions:
  - inicial 4'h0: all outputs 0. iniciar=1 -> preparacao.
  - preparacao 4'h1: zeraC=1, zeraR=1. Always -> espera_jogada.
  - espera_jogada 4'h2: timer increments each cycle.
    - jp=1 -> registra.
    - else timer==TIMEOUT_CYCLES-1 -> fim_timeout.
    - If jp and expiry occur in the same cycle, jp wins.
  - registra 4'h4: registraR=1. Always -> comparacao. The register holds the switches from the next edge on.
  - comparacao 4'h5: chavesIgualMemoria and fimC are sampled here.
    - !igual -> fim_errou.
    - igual & fimC -> fim_acertou.
    - igual & !fimC -> proximo.
  - proximo 4'h6: contaC=1, one cycle. Always -> espera_jogada.
  - fim_acertou 4'hA: pronto=1, acertou=1.
  - fim_errou 4'hE: pronto=1, errou=1.
  - fim_timeout 4'hD: pronto=1, timeout=1.
  - From any fim_* state: iniciar=1 -> preparacao; otherwise hold.
  - Any other code -> inicial.
- Timer: TW bits, reset value 0. Cleared to 0 in every state except espera_jogada, so each wait starts from 0.
  - Timeout fires exactly TIMEOUT_CYCLES cycles after entering espera_jogada with no jp.
- Latency: jp edge -> registra 1 cycle -> comparacao 1 cycle -> result state on the next edge. Per-move overhead after jp is 3 cycles (registra, comparacao, proximo).
- iniciar asserted while a round is running (states 1..6) is ignored.
- At most one of zeraC, contaC, registraR is asserted in any state.

Decomposition:
- Shared package exp3_pkg:
  - 4-bit state encoding constants (values above), shared with the 7-seg debug decoder.
  - TIMEOUT_CYCLES default.
- One natural sub-module: edge_detector (clock, reset_n, sinal -> pulso), reusable for the iniciar button in later experiments.
- Timer and FSM stay in this module.

Test Plan:
- Reset mid-round: drive into proximo, pulse reset_n=0 for 3 cycles -> db_estado=0, all outputs 0, timer=0. After release and iniciar -> db_estado=1 with zeraC=zeraR=1.
- Full win: iniciar, then 16 jogada edges, model returns igual=1 each time and fimC=1 on the 16th -> exactly 15 contaC pulses, then pronto=acertou=1, db_estado=A.
- Mismatch: igual=1 on moves 1-2, igual=0 on move 3 -> 2 contaC pulses, db_estado=E, errou=1, acertou=0, timeout=0.
- Timeout (TIMEOUT_CYCLES=20): no jogada after preparacao -> fim_timeout (db_estado=D, timeout=1) exactly 20 cycles after entering 2. Also jp on cycle 19 -> registra, not timeout.
- Held button: jogada held high 50 cycles through registra/comparacao/proximo -> exactly one registraR pulse. Back in espera_jogada the FSM stays until jogada falls and rises again.
- Restart: in fim_errou, iniciar=1 -> preparacao next cycle (errou=0, zeraC=1). A new round then proceeds normally.
